hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//   Pipeline hazard scheduler for the 5-stage MIPS core. Decides the D-stage stall from
//   Tuse/Tnew comparisons against the E and M stages and picks the D-stage forwarding
//   sources. Owns the HI/LO multiply/divide busy sequencer, and stalls HI/LO users in D
//   while a mult/div is in flight. Keeps a saturating stall-cycle counter for debug.
// PARAMETERS
//   MULT_CYC  5   busy cycles after a mult/multu start, excluding the start cycle
//   DIV_CYC   10  busy cycles after a div/divu start, excluding the start cycle
//   CNT_W     4   md counter width; must hold max(MULT_CYC, DIV_CYC)
//   STAT_W    16  stall statistics counter width
// PORTS
//   clk         in   1      clock; all state updates on the rising edge
//   reset       in   1      synchronous, active-high
//   D_rs        in   5      D-stage rs address
//   D_rt        in   5      D-stage rt address
//   D_Tuse_rs   in   2      cycles until D needs rs (3 = not used)
//   D_Tuse_rt   in   2      cycles until D needs rt (3 = not used)
//   D_is_md     in   1      D instr touches HI/LO (mult*/div*/mfhi/mflo/mthi/mtlo)
//   E_A3        in   5      E-stage destination register (0 = none)
//   E_Tnew      in   2      cycles until the E result is available
//   M_A3        in   5      M-stage destination register (0 = none)
//   M_Tnew      in   2      cycles until the M result is available
//   E_start     in   1      mult/div enters E this cycle (never a flushed bubble)
//   E_md_div    in   1      with E_start: 1 = div/divu, 0 = mult/multu
//   stall       out  1      freeze PC and F/D, insert bubble into D/E
//   fwd_rs_D    out  2      00 regfile, 01 E result, 10 M result
//   fwd_rt_D    out  2      same encoding as fwd_rs_D
//   md_busy     out  1      mult/div in progress (includes the start cycle)
//   md_done     out  1      1-cycle pulse in the last busy cycle
//   md_err      out  1      sticky: E_start was seen while the counter was nonzero
//   stall_cnt   out  STAT_W count of stalled cycles, saturating
// BEHAVIOUR
//   Reset: md_cnt=0, md_err=0, stall_cnt=0. With reset held and all inputs 0, every
//     output is 0.
//   Register hazard (combinational): rs_hzd =
//       (D_rs!=0 & D_rs==E_A3 & D_Tuse_rs<E_Tnew)
//     | (D_rs!=0 & D_rs==M_A3 & D_Tuse_rs<M_Tnew);
//     rt_hzd is the same with D_rt/D_Tuse_rt.
//   MD hazard: md_hzd = D_is_md & md_busy.
//   stall = rs_hzd | rt_hzd | md_hzd, registered nowhere (same-cycle).
//   Forwarding:
//     fwd_rs_D=01 if D_rs!=0 & D_rs==E_A3 & E_Tnew==0;
//     else 10 if D_rs!=0 & D_rs==M_A3 & M_Tnew==0;
//     else 00. E beats M. fwd_rt_D is the same with D_rt.
//   MD sequencer, states IDLE (md_cnt==0) / RUN (md_cnt!=0):
//     IDLE & E_start: md_cnt <= E_md_div ? DIV_CYC : MULT_CYC.
//     RUN: md_cnt <= md_cnt-1. A new E_start is ignored (count not reloaded) and sets md_err.
//     md_busy = E_start | (md_cnt!=0); md_done = (md_cnt==1).
//     Start in cycle t -> busy for cycles t..t+N; md_done at t+N; HI/LO readable at t+N+1.
//   stall_cnt increments on every cycle with stall=1 and holds at all-ones.
//   Reset mid-operation: md_cnt is cleared and md_busy drops in the next cycle unless
//     E_start is present.
//   Tnew inputs are already stage-relative; this block never decrements them.
// TESTING
//   1 Load-use: E_A3=5, E_Tnew=2, D_rs=5, D_Tuse_rs=1 -> stall=1, fwd_rs_D=00, stall_cnt +1.
//   2 Zero reg: E_A3=0, E_Tnew=2, D_rs=0, D_Tuse_rs=0 -> stall=0, fwd_rs_D=00.
//   3 Priority: E_A3=M_A3=7, E_Tnew=M_Tnew=0, D_rt=7 -> fwd_rt_D=01; with E_A3=0 -> 10.
//   4 Mult: E_start=1, E_md_div=0 at t -> md_busy t..t+5, md_done only at t+5;
//     D_is_md=1 at t+3 -> stall=1; at t+6 -> stall=0.
//   5 Div, then reset asserted at t+4 -> md_busy=0 at t+5, md_err=0; an extra E_start
//     at t+2 before the reset -> md_err=1 at t+3.
//   6 Saturation (STAT_W=4): hold stall for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_sched.sv
// ---------------------------------------------------------------------------
// hazard_sched
//   D-stage hazard scheduler for the 5-stage MIPS core.
//   - Compares D-stage Tuse against E/M-stage Tnew to decide the D stall.
//   - Selects D-stage forwarding sources for rs and rt (E beats M).
//   - Sequences the HI/LO multiply/divide unit and stalls HI/LO users in D
//     while an operation is in flight.
//   - Keeps a saturating count of stalled cycles for debug.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   D_rs, D_rt          D-stage source register addresses
//   D_Tuse_rs/_rt       cycles until D needs the operand (3 = unused)
//   D_is_md             D instruction touches HI/LO
//   E_A3, E_Tnew        E-stage destination and result latency
//   M_A3, M_Tnew        M-stage destination and result latency
//   E_start, E_md_div   mult/div enters E this cycle; 1 = divide
//   stall               freeze PC and F/D, bubble into D/E (combinational)
//   fwd_rs_D, fwd_rt_D  00 regfile, 01 E result, 10 M result
//   md_busy             mult/div in progress, including the start cycle
//   md_done             pulse in the last busy cycle
//   md_err              sticky: start seen while an operation was running
//   stall_cnt           saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic [1:0]        D_Tuse_rs,
  input  logic [1:0]        D_Tuse_rt,
  input  logic              D_is_md,
  input  logic [4:0]        E_A3,
  input  logic [1:0]        E_Tnew,
  input  logic [4:0]        M_A3,
  input  logic [1:0]        M_Tnew,
  input  logic              E_start,
  input  logic              E_md_div,
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic              md_busy,
  output logic              md_done,
  output logic              md_err,
  output logic [STAT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, RUN} md_state_t;

  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;

  logic rs_match_e, rs_match_m, rt_match_e, rt_match_m;
  logic rs_hzd, rt_hzd, md_hzd;

  // Register 0 never carries a real dependency.
  assign rs_match_e = (D_rs != 5'd0) && (D_rs == E_A3);
  assign rs_match_m = (D_rs != 5'd0) && (D_rs == M_A3);
  assign rt_match_e = (D_rt != 5'd0) && (D_rt == E_A3);
  assign rt_match_m = (D_rt != 5'd0) && (D_rt == M_A3);

  // A producer stalls D only if its result arrives later than D needs it.
  assign rs_hzd = (rs_match_e && (D_Tuse_rs < E_Tnew)) ||
                  (rs_match_m && (D_Tuse_rs < M_Tnew));
  assign rt_hzd = (rt_match_e && (D_Tuse_rt < E_Tnew)) ||
                  (rt_match_m && (D_Tuse_rt < M_Tnew));

  assign md_busy = E_start || (md_cnt != '0);
  assign md_done = (md_cnt == CNT_W'(1));
  assign md_hzd  = D_is_md && md_busy;

  assign stall = rs_hzd || rt_hzd || md_hzd;

  // Forward only results that are already available; the younger E stage wins.
  always_comb begin
    fwd_rs_D = 2'b00;
    if (rs_match_e && (E_Tnew == 2'd0))
      fwd_rs_D = 2'b01;
    else if (rs_match_m && (M_Tnew == 2'd0))
      fwd_rs_D = 2'b10;
  end

  always_comb begin
    fwd_rt_D = 2'b00;
    if (rt_match_e && (E_Tnew == 2'd0))
      fwd_rt_D = 2'b01;
    else if (rt_match_m && (M_Tnew == 2'd0))
      fwd_rt_D = 2'b10;
  end

  // md sequencer: RUN while md_cnt is nonzero. A start during RUN is not
  // reloaded; it only flags md_err so the collision is visible in debug.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= IDLE;
      md_cnt   <= '0;
      md_err   <= 1'b0;
    end else begin
      case (md_state)
        IDLE: begin
          if (E_start) begin
            md_cnt   <= E_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
            md_state <= RUN;
          end
        end
        RUN: begin
          if (E_start)
            md_err <= 1'b1;
          md_cnt <= md_cnt - CNT_W'(1);
          if (md_cnt == CNT_W'(1))
            md_state <= IDLE;
        end
        default: begin
          md_state <= IDLE;
          md_cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating stall statistics.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + STAT_W'(1);
  end

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        D_rs, D_rt, E_A3, M_A3;
  logic [1:0]        D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic              D_is_md, E_start, E_md_div;
  logic              stall, md_busy, md_done, md_err;
  logic [1:0]        fwd_rs_D, fwd_rt_D;
  logic [STAT_W-1:0] stall_cnt;

  hazard_sched #(
    .MULT_CYC(5), .DIV_CYC(10), .CNT_W(4), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_is_md(D_is_md), .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3),
    .M_Tnew(M_Tnew), .E_start(E_start), .E_md_div(E_md_div),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .md_busy(md_busy), .md_done(md_done), .md_err(md_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Signal selectors for scoreboard entries.
  localparam int S_STALL = 0, S_FRS = 1, S_FRT = 2, S_BUSY = 3,
                 S_DONE  = 4, S_ERR = 5, S_CNT = 6;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic int observe(int sel);
    case (sel)
      S_STALL: return int'(stall);
      S_FRS:   return int'(fwd_rs_D);
      S_FRT:   return int'(fwd_rt_D);
      S_BUSY:  return int'(md_busy);
      S_DONE:  return int'(md_done);
      S_ERR:   return int'(md_err);
      S_CNT:   return int'(stall_cnt);
      default: return -1;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    q.push_back(e);
  endtask

  // Check pending expectations away from the active edge, then advance.
  task automatic cyc();
    exp_t e;
    int   obs;
    @(negedge clk);
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sel);
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_rs = 0; D_rt = 0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_is_md = 0;
    E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0; E_start = 0; E_md_div = 0;
  endtask

  initial begin
    reset = 1'b1;
    D_rs = 0; D_rt = 0; D_Tuse_rs = 0; D_Tuse_rt = 0; D_is_md = 0;
    E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0; E_start = 0; E_md_div = 0;

    // Reset state with all inputs zero.
    cyc();
    expect_val("rst_stall", S_STALL, 0);
    expect_val("rst_frs",   S_FRS,   0);
    expect_val("rst_frt",   S_FRT,   0);
    expect_val("rst_busy",  S_BUSY,  0);
    expect_val("rst_done",  S_DONE,  0);
    expect_val("rst_err",   S_ERR,   0);
    expect_val("rst_cnt",   S_CNT,   0);
    cyc();
    reset = 1'b0;
    idle_inputs();

    // Load-use against E.
    E_A3 = 5; E_Tnew = 2; D_rs = 5; D_Tuse_rs = 1;
    expect_val("loaduse_stall", S_STALL, 1);
    expect_val("loaduse_frs",   S_FRS,   0);
    expect_val("loaduse_cnt0",  S_CNT,   0);
    cyc();
    idle_inputs();
    expect_val("loaduse_cnt1",  S_CNT,   1);
    expect_val("idle_stall",    S_STALL, 0);
    cyc();

    // rt hazard against M, then Tuse == Tnew boundary (no stall).
    M_A3 = 9; M_Tnew = 1; D_rt = 9; D_Tuse_rt = 0;
    expect_val("m_rt_stall", S_STALL, 1);
    cyc();
    D_Tuse_rt = 1;
    expect_val("m_rt_eq_nostall", S_STALL, 0);
    expect_val("m_rt_cnt2",       S_CNT,   2);
    cyc();
    idle_inputs();

    // Register zero never hazards.
    E_A3 = 0; E_Tnew = 2; D_rs = 0; D_Tuse_rs = 0;
    expect_val("zero_stall", S_STALL, 0);
    expect_val("zero_frs",   S_FRS,   0);
    cyc();
    idle_inputs();

    // Forwarding priority: E beats M, M when E absent.
    E_A3 = 7; M_A3 = 7; E_Tnew = 0; M_Tnew = 0; D_rt = 7; D_Tuse_rt = 0;
    expect_val("prio_frt_e",  S_FRT,   1);
    expect_val("prio_stall",  S_STALL, 0);
    cyc();
    E_A3 = 0; D_rs = 7; D_Tuse_rs = 0;
    expect_val("prio_frt_m",  S_FRT,   2);
    expect_val("prio_frs_m",  S_FRS,   2);
    cyc();
    idle_inputs();

    // Multiply: busy t..t+5, done only at t+5, HI/LO users stall meanwhile.
    E_start = 1; E_md_div = 0;
    expect_val("mul_busy_t", S_BUSY, 1);
    expect_val("mul_done_t", S_DONE, 0);
    cyc();
    E_start = 0;
    for (int i = 1; i <= 6; i++) begin
      D_is_md = (i == 3 || i == 6);
      expect_val($sformatf("mul_busy_t%0d", i), S_BUSY, (i <= 5) ? 1 : 0);
      expect_val($sformatf("mul_done_t%0d", i), S_DONE, (i == 5) ? 1 : 0);
      if (i == 3) expect_val("mul_md_stall_t3",   S_STALL, 1);
      if (i == 6) expect_val("mul_md_nostall_t6", S_STALL, 0);
      cyc();
    end
    idle_inputs();
    expect_val("mul_err", S_ERR, 0);
    expect_val("mul_cnt", S_CNT, 3);
    cyc();

    // Divide with a colliding start at t+2, then reset at t+4.
    E_start = 1; E_md_div = 1;
    expect_val("div_busy_t", S_BUSY, 1);
    cyc();
    E_start = 0; E_md_div = 0;
    expect_val("div_busy_t1", S_BUSY, 1);
    cyc();
    E_start = 1;
    expect_val("div_err_t2", S_ERR, 0);
    cyc();
    E_start = 0;
    expect_val("div_err_t3",  S_ERR,  1);
    expect_val("div_busy_t3", S_BUSY, 1);
    expect_val("div_done_t3", S_DONE, 0);
    cyc();
    reset = 1'b1;
    expect_val("div_busy_t4", S_BUSY, 1);
    cyc();
    reset = 1'b0;
    expect_val("div_busy_t5", S_BUSY, 0);
    expect_val("div_err_t5",  S_ERR,  0);
    expect_val("div_done_t5", S_DONE, 0);
    expect_val("div_cnt_t5",  S_CNT,  0);
    cyc();

    // Saturation: 20 stalled cycles, counter stops at 15.
    E_A3 = 3; E_Tnew = 2; D_rs = 3; D_Tuse_rs = 0;
    for (int i = 0; i < 20; i++) begin
      expect_val($sformatf("sat_cnt_%0d", i), S_CNT, (i < 15) ? i : 15);
      cyc();
    end
    idle_inputs();
    expect_val("sat_final", S_CNT,   15);
    expect_val("sat_idle",  S_STALL, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
